// File: rtl/fa_pkg.sv
// Shared types and helpers for the chunk-serial adder and its bench.
package fa_pkg;

  // Operation phases of the chunk-serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fa_state_t;

  // Width of the chunk index: clog2 of the chunk count, never narrower than one bit.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational ripple of CHUNK full-adder cells. Also exposes the carry into
// the top cell so the caller can derive signed overflow for the final chunk.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic cy;

  // Ripple the carry bit by bit, capturing the carry entering the top cell.
  always_comb begin
    sum   = '0;
    cy    = ci;
    c_msb = ci;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = cy;
      sum[i] = x[i] ^ y[i] ^ cy;
      cy     = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/fa_seq_nb.sv
// Chunk-serial multi-cycle adder: WIDTH-bit a + b + c_in computed CHUNK bits per
// clock through one shared fa_chunk, with valid/ready handshakes on both sides.
// The result (s, c_out, overflow) persists until the next operation overwrites it;
// consumers qualify it with out_valid.
module fa_seq_nb
  import fa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("fa_seq_nb: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  fa_state_t        state;
  fa_state_t        state_nxt;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CHUNK-1:0] x_sel;
  logic [CHUNK-1:0] y_sel;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_co;
  logic             chunk_c_msb;
  logic             last;
  logic             accept;

  assign last   = (idx == LAST_IDX);
  assign accept = (state == IDLE) && in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: one pass through RUN per chunk, then hold in DONE until drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come from state alone, so no input-to-output combinational path.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand latches; data only, so no reset. Later changes on a/b are invisible.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Select the operand chunks addressed by idx with constant part-selects.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        x_sel = a_q[i*CHUNK +: CHUNK];
        y_sel = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  fa_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x     (x_sel),
    .y     (y_sel),
    .ci    (carry),
    .sum   (chunk_sum),
    .co    (chunk_co),
    .c_msb (chunk_c_msb)
  );

  // Chunk index, running carry and result registers; sum chunks are written in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      s        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) s[i*CHUNK +: CHUNK] <= chunk_sum;
          end
          carry <= chunk_co;
          if (last) begin
            c_out    <= chunk_co;
            overflow <= chunk_c_msb ^ chunk_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_seq_nb.sv
// Bench for fa_seq_nb: three instances (16/4, 16/16, 8/2) driven one at a time,
// expected results queued at issue and compared when out_valid appears.
module tb_fa_seq_nb;
  import fa_pkg::*;

  logic clk;
  logic rst_n;

  logic        in_valid_v  [3];
  logic        out_ready_v [3];
  logic        c_in_v      [3];
  logic [15:0] a_v         [3];
  logic [15:0] b_v         [3];

  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic [15:0] s_v         [3];
  logic        c_out_v     [3];
  logic        ovf_v       [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [15:0] s0, s1;
  logic [7:0]  s2;

  int checks;
  int errors;
  int nch [3];
  logic [17:0] exp_q [$];

  fa_seq_nb #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .a(a_v[0]), .b(b_v[0]), .c_in(c_in_v[0]), .out_valid(ov0),
    .out_ready(out_ready_v[0]), .s(s0), .c_out(co0), .overflow(of0)
  );

  fa_seq_nb #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .a(a_v[1]), .b(b_v[1]), .c_in(c_in_v[1]), .out_valid(ov1),
    .out_ready(out_ready_v[1]), .s(s1), .c_out(co1), .overflow(of1)
  );

  fa_seq_nb #(.WIDTH(8), .CHUNK(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .c_in(c_in_v[2]), .out_valid(ov2),
    .out_ready(out_ready_v[2]), .s(s2), .c_out(co2), .overflow(of2)
  );

  always_comb begin
    in_ready_v[0] = ir0; in_ready_v[1] = ir1; in_ready_v[2] = ir2;
    out_valid_v[0] = ov0; out_valid_v[1] = ov1; out_valid_v[2] = ov2;
    s_v[0] = s0; s_v[1] = s1; s_v[2] = {8'h00, s2};
    c_out_v[0] = co0; c_out_v[1] = co1; c_out_v[2] = co2;
    ovf_v[0] = of0; ovf_v[1] = of1; ovf_v[2] = of2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {overflow, c_out, s} with s zero-extended to 16 bits.
  function automatic logic [17:0] model(input int sel, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [16:0] f16;
    logic [8:0]  f8;
    logic        ov;
    if (sel == 2) begin
      f8 = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'd0, ci};
      ov = (x[7] == y[7]) && (f8[7] != x[7]);
      return {ov, f8[8], 8'h00, f8[7:0]};
    end
    f16 = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    ov  = (x[15] == y[15]) && (f16[15] != x[15]);
    return {ov, f16[16], f16[15:0]};
  endfunction

  // Issue one op on instance sel, scramble inputs after accept, wait for result,
  // optionally stall out_ready for 'hold' cycles, then drain. lat=-1 on timeout.
  task automatic do_op(input int sel, input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input int hold, output logic [17:0] got, output int lat);
    int n;
    n = 0;
    while (!in_ready_v[sel] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a_v[sel] = x; b_v[sel] = y; c_in_v[sel] = ci; in_valid_v[sel] = 1'b1;
    exp_q.push_back(model(sel, x, y, ci));
    @(posedge clk); #1;
    in_valid_v[sel] = 1'b0;
    a_v[sel] = 16'($urandom); b_v[sel] = 16'($urandom); c_in_v[sel] = 1'($urandom);
    lat = 0;
    while (!out_valid_v[sel] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid_v[sel]) lat = -1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    got = {ovf_v[sel], c_out_v[sel], s_v[sel]};
    out_ready_v[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
    checks++; if (s0 !== 16'h0000) begin errors++; $display("FAIL reset_s got %h want 0000", s0); end
    checks++; if (co0 !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b want 0", co0); end
    checks++; if (of0 !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", of0); end
    checks++; if (ir1 !== 1'b1 || ir2 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_other got %b%b want 11", ir1, ir2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];
    logic [17:0] want [4];
    logic [17:0] got;
    logic [17:0] e;
    int lat;
    va = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h5555};
    vb = '{16'h0001, 16'h0001, 16'h8000, 16'hAAAA};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1};
    want = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000},
             {1'b1, 1'b1, 16'h0001}, {1'b0, 1'b1, 16'h0000}};
    for (int i = 0; i < 4; i++) begin
      do_op(0, va[i], vb[i], vc[i], 0, got, lat);
      e = 18'h0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++;
      if (got !== want[i] || e !== want[i]) begin
        errors++; $display("FAIL vector%0d got %h model %h want %h", i, got, e, want[i]);
      end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL vector%0d_latency got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] e;
    int lat;
    int stray;
    while (!ir0) begin @(posedge clk); #1; end
    a_v[0] = 16'h1234; b_v[0] = 16'h4321; c_in_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    exp_q.push_back(model(0, 16'h1234, 16'h4321, 1'b0));
    @(posedge clk); #1;
    // keep offering different operands through RUN and DONE
    a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF; c_in_v[0] = 1'b1;
    lat = 0;
    while (!ov0 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    e = 18'h0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ov0 !== 1'b1 || {of0, co0, s0} !== e || ir0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b r=%b res=%h want v=1 r=0 res=%h", i, ov0, ir0,
                 {of0, co0, s0}, e);
      end
      @(posedge clk); #1;
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
      errors++; $display("FAIL bp_drain got v=%b r=%b want v=0 r=1", ov0, ir0);
    end
    stray = 0;
    repeat (4) begin @(posedge clk); #1; if (ov0 || !ir0) stray++; end
    checks++;
    if (stray != 0 || s0 !== 16'h5555) begin
      errors++; $display("FAIL bp_no_capture got stray=%0d s=%h want 0 s=5555", stray, s0);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [17:0] got;
    logic [17:0] e;
    int lat;
    int pulses;
    while (!ir0) begin @(posedge clk); #1; end
    a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF; c_in_v[0] = 1'b1; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0 || s0 !== 16'h0000 || co0 !== 1'b0 || of0 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got r=%b v=%b s=%h c=%b o=%b want 1 0 0000 0 0", ir0, ov0, s0, co0, of0);
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (ov0) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrun_pulse got %0d want 0", pulses); end
    do_op(0, 16'h0003, 16'h0004, 1'b0, 1, got, lat);
    e = 18'h0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (got !== {2'b00, 16'h0007} || e !== got) begin
      errors++; $display("FAIL midrun_next got %h model %h want 00007", got, e);
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL midrun_latency got %0d want 4", lat); end
  endtask

  task automatic test_random(input int sel, input int n);
    logic [17:0] got;
    logic [17:0] e;
    int lat;
    int bad_res;
    int bad_lat;
    bad_res = 0;
    bad_lat = 0;
    for (int i = 0; i < n; i++) begin
      do_op(sel, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2), got, lat);
      e = 18'h3FFFF;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        if (bad_res < 5) $display("FAIL random%0d_result op%0d got %h want %h", sel, i, got, e);
        bad_res++;
      end
      checks++;
      if (lat != nch[sel]) begin
        errors++;
        if (bad_lat < 5) $display("FAIL random%0d_latency op%0d got %0d want %0d", sel, i, lat, nch[sel]);
        bad_lat++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nch = '{4, 1, 4};
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; c_in_v[i] = 1'b0;
      a_v[i] = 16'h0; b_v[i] = 16'h0;
    end
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_random(0, 200);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
